// File: rtl/soc_pkg.sv
// Shared SoC types: OBI channel structs, the peripheral address map and demux defaults.
package soc_pkg;

    localparam int unsigned AddrWidth      = 32;
    localparam int unsigned DataWidth      = 32;
    localparam int unsigned IdWidth        = 4;
    localparam int unsigned NumPeriphRules = 6;
    localparam int unsigned MaxPeriphTrans = 4;

    localparam logic [DataWidth-1:0]      ErrRspData          = 32'hBADC_AB1E;
    localparam logic [NumPeriphRules-1:0] PeriphRuleEnDefault = '1;

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } sbr_obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } sbr_obi_rsp_t;

    typedef struct packed {
        logic [7:0]           idx;
        logic [AddrWidth-1:0] start_addr;
        logic [AddrWidth-1:0] end_addr;
    } addr_map_rule_t;

    // Flash, SRAM, PSRAM, UART, fabric config, fabric; end_addr is exclusive.
    localparam addr_map_rule_t [NumPeriphRules-1:0] periph_addr_map = '{
        0: '{idx: 8'd1, start_addr: 32'h0000_0000, end_addr: 32'h1000_0000},
        1: '{idx: 8'd2, start_addr: 32'h1000_0000, end_addr: 32'h2000_0000},
        2: '{idx: 8'd3, start_addr: 32'h2000_0000, end_addr: 32'h3000_0000},
        3: '{idx: 8'd4, start_addr: 32'h3000_0000, end_addr: 32'h4000_0000},
        4: '{idx: 8'd5, start_addr: 32'h4000_0000, end_addr: 32'h5000_0000},
        5: '{idx: 8'd6, start_addr: 32'h5000_0000, end_addr: 32'h6000_0000}
    };

endpackage

// File: rtl/obi_err_sbr.sv
// One-cycle OBI error subordinate: grants immediately, answers with err=1 the next cycle.
module obi_err_sbr
    import soc_pkg::*;
#(
    parameter logic [DataWidth-1:0] ErrData = ErrRspData
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req,
    input  logic [IdWidth-1:0] i_aid,
    output logic               o_gnt,
    output logic               o_rvalid,
    output obi_r_chan_t        o_r
);

    logic               r_valid;
    logic [IdWidth-1:0] r_rid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_rid   <= '0;
        end else begin
            r_valid <= i_req;
            if (i_req) r_rid <= i_aid;
        end
    end

    assign o_gnt    = i_req;
    assign o_rvalid = r_valid;

    always_comb begin
        o_r = '0;
        if (r_valid) begin
            o_r.rdata = ErrData;
            o_r.rid   = r_rid;
            o_r.err   = 1'b1;
        end
    end

endmodule

// File: rtl/obi_periph_demux.sv
// OBI address demultiplexer towards the peripheral subordinates with in-order response tracking.
module obi_periph_demux
    import soc_pkg::*;
#(
    parameter int unsigned                    NumRules = NumPeriphRules,
    parameter int unsigned                    MaxTrans = MaxPeriphTrans,
    parameter addr_map_rule_t [NumRules-1:0]  AddrMap  = periph_addr_map,
    parameter logic [DataWidth-1:0]           ErrData  = ErrRspData
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumRules-1:0]          rule_en_i,
    input  sbr_obi_req_t                 mgr_req_i,
    output sbr_obi_rsp_t                 mgr_rsp_o,
    output sbr_obi_req_t [NumRules-1:0]  sbr_req_o,
    input  sbr_obi_rsp_t [NumRules-1:0]  sbr_rsp_i,
    output logic                         busy_o
);

    localparam int unsigned SelW = $clog2(NumRules + 1);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

    logic [SelW-1:0]     r_fifo [MaxTrans];
    logic [PtrW-1:0]     r_wptr, r_rptr;
    logic [CntW-1:0]     r_cnt;
    logic [SelW-1:0]     r_last_sel;

    logic [SelW-1:0]     w_sel, w_head;
    logic                w_hit, w_gate, w_fwd, w_tgt_gnt, w_push, w_pop;
    logic [NumRules-1:0] w_en_shift;
    logic                w_err_req, w_err_gnt, w_err_rvalid;
    obi_r_chan_t         w_err_r;

    // Lowest array index wins; the enable bit is looked up by the rule's idx.
    always_comb begin
        w_sel      = '0;
        w_hit      = 1'b0;
        w_en_shift = '0;
        for (int unsigned k = 0; k < NumRules; k++) begin
            w_en_shift = rule_en_i >> (32'(AddrMap[k].idx) - 32'd1);
            if (!w_hit && w_en_shift[0] &&
                mgr_req_i.a.addr >= AddrMap[k].start_addr &&
                mgr_req_i.a.addr <  AddrMap[k].end_addr) begin
                w_hit = 1'b1;
                w_sel = AddrMap[k].idx[SelW-1:0];
            end
        end
    end

    assign w_gate    = (r_cnt < CntW'(MaxTrans)) && ((r_cnt == '0) || (w_sel == r_last_sel));
    assign w_fwd     = mgr_req_i.req && w_gate && !rst_i;
    assign w_err_req = w_fwd && (w_sel == '0);
    assign w_head    = r_fifo[r_rptr];

    always_comb begin
        w_tgt_gnt = w_err_gnt;
        for (int unsigned k = 0; k < NumRules; k++) begin
            sbr_req_o[k].req = w_fwd && (w_sel == SelW'(k + 1));
            sbr_req_o[k].a   = mgr_req_i.a;
            if (w_sel == SelW'(k + 1)) w_tgt_gnt = sbr_rsp_i[k].gnt;
        end
    end

    // Only the head target may answer; anything else, or anything at cnt=0, is dropped.
    always_comb begin
        mgr_rsp_o = '0;
        if (r_cnt != '0) begin
            if (w_head == '0) begin
                mgr_rsp_o.rvalid = w_err_rvalid;
                mgr_rsp_o.r      = w_err_r;
            end
            for (int unsigned k = 0; k < NumRules; k++) begin
                if (w_head == SelW'(k + 1)) begin
                    mgr_rsp_o.rvalid = sbr_rsp_i[k].rvalid;
                    mgr_rsp_o.r      = sbr_rsp_i[k].r;
                end
            end
        end
        mgr_rsp_o.gnt = w_fwd && w_tgt_gnt;
    end

    assign w_push = mgr_rsp_o.gnt;
    assign w_pop  = mgr_rsp_o.rvalid;
    assign busy_o = (r_cnt != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_last_sel <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_sel;
                r_last_sel     <= w_sel;
                r_wptr         <= (r_wptr == PtrW'(MaxTrans - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrW'(MaxTrans - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end

    obi_err_sbr #(
        .ErrData(ErrData)
    ) u_err_sbr (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_req    (w_err_req),
        .i_aid    (mgr_req_i.a.aid),
        .o_gnt    (w_err_gnt),
        .o_rvalid (w_err_rvalid),
        .o_r      (w_err_r)
    );

endmodule

// File: tb/tb_obi_periph_demux.sv
// Directed bench for obi_periph_demux: routing, error responder, ordering gate and reset.
module tb_obi_periph_demux;
    import soc_pkg::*;

    logic                clk;
    logic                rst;
    logic [5:0]          rule_en;
    sbr_obi_req_t        mgr_req;
    sbr_obi_rsp_t        mgr_rsp;
    sbr_obi_req_t [5:0]  sbr_req;
    sbr_obi_rsp_t [5:0]  sbr_rsp;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;

    obi_periph_demux #(
        .NumRules (6),
        .MaxTrans (4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .rule_en_i (rule_en),
        .mgr_req_i (mgr_req),
        .mgr_rsp_o (mgr_rsp),
        .sbr_req_o (sbr_req),
        .sbr_rsp_i (sbr_rsp),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] req_vec();
        logic [5:0] v;
        for (int k = 0; k < 6; k++) v[k] = sbr_req[k].req;
        return v;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drv(input logic req, input logic [31:0] addr, input logic we, input logic [3:0] aid);
        mgr_req.req     = req;
        mgr_req.a.addr  = addr;
        mgr_req.a.we    = we;
        mgr_req.a.be    = 4'hF;
        mgr_req.a.wdata = 32'hCAFE_0000 | 32'(aid);
        mgr_req.a.aid   = aid;
    endtask

    task automatic rsp(input int port, input logic [31:0] rdata, input logic [3:0] rid);
        sbr_rsp[port].rvalid  = 1'b1;
        sbr_rsp[port].r.rdata = rdata;
        sbr_rsp[port].r.rid   = rid;
        sbr_rsp[port].r.err   = 1'b0;
    endtask

    task automatic clr_rvalid();
        for (int k = 0; k < 6; k++) sbr_rsp[k].rvalid = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        rule_en = 6'b111111;
        mgr_req = '0;
        sbr_rsp = '0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_mgr_rsp", 64'(mgr_rsp), 64'd0);
        chk("rst_req_vec", 64'(req_vec()), 64'd0);
        rst = 1'b0;

        // Read to SRAM (port 1)
        cyc(); drv(1'b1, 32'h1000_0004, 1'b0, 4'd3); sbr_rsp[1].gnt = 1'b1; #1;
        chk("sram_req_vec", 64'(req_vec()), 64'b000010);
        chk("sram_gnt",     64'(mgr_rsp.gnt), 64'd1);
        chk("sram_fwd_addr", 64'(sbr_req[1].a.addr), 64'h1000_0004);
        cyc(); drv(1'b0, '0, 1'b0, 4'd0); sbr_rsp[1].gnt = 1'b0; rsp(1, 32'h1234_5678, 4'd3); #1;
        chk("sram_busy",   64'(busy), 64'd1);
        chk("sram_rvalid", 64'(mgr_rsp.rvalid), 64'd1);
        chk("sram_rdata",  64'(mgr_rsp.r.rdata), 64'h1234_5678);
        cyc(); clr_rvalid(); #1;
        chk("sram_idle", 64'(busy), 64'd0);

        // Unmapped address -> error responder
        cyc(); drv(1'b1, 32'h6000_0000, 1'b0, 4'd5); #1;
        chk("err_gnt",     64'(mgr_rsp.gnt), 64'd1);
        chk("err_req_vec", 64'(req_vec()), 64'd0);
        chk("err_no_rv",   64'(mgr_rsp.rvalid), 64'd0);
        cyc(); drv(1'b0, '0, 1'b0, 4'd0); #1;
        chk("err_rvalid", 64'(mgr_rsp.rvalid), 64'd1);
        chk("err_err",    64'(mgr_rsp.r.err), 64'd1);
        chk("err_rdata",  64'(mgr_rsp.r.rdata), 64'hBADC_AB1E);
        chk("err_rid",    64'(mgr_rsp.r.rid), 64'd5);
        cyc(); #1;
        chk("err_idle", 64'(busy), 64'd0);
        chk("err_rv_clr", 64'(mgr_rsp.rvalid), 64'd0);

        // Back-to-back error requests
        cyc(); drv(1'b1, 32'hF000_0000, 1'b0, 4'd1); #1;
        chk("b2b_gnt1", 64'(mgr_rsp.gnt), 64'd1);
        cyc(); drv(1'b1, 32'hF000_0004, 1'b0, 4'd2); #1;
        chk("b2b_gnt2", 64'(mgr_rsp.gnt), 64'd1);
        chk("b2b_rid1", 64'({mgr_rsp.rvalid, mgr_rsp.r.rid}), 64'h11);
        cyc(); drv(1'b0, '0, 1'b0, 4'd0); #1;
        chk("b2b_rid2", 64'({mgr_rsp.rvalid, mgr_rsp.r.rid}), 64'h12);
        cyc(); #1;
        chk("b2b_idle", 64'(busy), 64'd0);

        // Disabled rule 6 -> error, re-enabled -> port 5
        rule_en = 6'b011111;
        cyc(); drv(1'b1, 32'h5000_0010, 1'b0, 4'd7); sbr_rsp[5].gnt = 1'b1; #1;
        chk("dis_req_vec", 64'(req_vec()), 64'd0);
        chk("dis_gnt",     64'(mgr_rsp.gnt), 64'd1);
        cyc(); drv(1'b0, '0, 1'b0, 4'd0); #1;
        chk("dis_err", 64'({mgr_rsp.rvalid, mgr_rsp.r.err}), 64'b11);
        rule_en = 6'b111111;
        cyc(); drv(1'b1, 32'h5000_0010, 1'b0, 4'd8); #1;
        chk("en_req_vec", 64'(req_vec()), 64'b100000);
        chk("en_gnt",     64'(mgr_rsp.gnt), 64'd1);
        cyc(); drv(1'b0, '0, 1'b0, 4'd0); sbr_rsp[5].gnt = 1'b0; rsp(5, 32'h5555_AAAA, 4'd8); #1;
        chk("en_rdata", 64'({mgr_rsp.rvalid, mgr_rsp.r.err, mgr_rsp.r.rdata}), {30'd0, 2'b10, 32'h5555_AAAA});
        cyc(); clr_rvalid(); #1;
        chk("en_idle", 64'(busy), 64'd0);

        // Outstanding limit on UART (port 3)
        sbr_rsp[3].gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); drv(1'b1, 32'h3000_0000 + 32'(4 * i), 1'b1, 4'(i)); #1;
            chk("lim_gnt", 64'(mgr_rsp.gnt), 64'd1);
        end
        cyc(); drv(1'b1, 32'h3000_0010, 1'b1, 4'd4); #1;
        chk("lim_full_gnt", 64'(mgr_rsp.gnt), 64'd0);
        chk("lim_full_req", 64'(req_vec()), 64'd0);
        cyc(); rsp(3, 32'hA1, 4'd0); #1;
        chk("lim_pop_gnt",  64'(mgr_rsp.gnt), 64'd0);
        chk("lim_pop_rv",   64'({mgr_rsp.rvalid, mgr_rsp.r.rdata}), {31'd0, 1'b1, 32'hA1});
        cyc(); clr_rvalid(); #1;
        chk("lim_reopen", 64'(mgr_rsp.gnt), 64'd1);
        cyc(); drv(1'b0, '0, 1'b0, 4'd0); sbr_rsp[3].gnt = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            rsp(3, 32'hA0 + 32'(i), 4'(i - 1)); #1;
            chk("lim_order", 64'({mgr_rsp.rvalid, mgr_rsp.r.rdata}), {31'd0, 1'b1, 32'hA0 + 32'(i)});
            cyc();
        end
        clr_rvalid(); #1;
        chk("lim_idle", 64'(busy), 64'd0);

        // Target switch: Flash outstanding blocks PSRAM
        cyc(); drv(1'b1, 32'h0000_0100, 1'b0, 4'd1); sbr_rsp[0].gnt = 1'b1; #1;
        chk("sw_flash_gnt", 64'(mgr_rsp.gnt), 64'd1);
        cyc(); drv(1'b1, 32'h2000_0000, 1'b0, 4'd2); sbr_rsp[0].gnt = 1'b0; sbr_rsp[2].gnt = 1'b1; #1;
        chk("sw_block_req", 64'(req_vec()), 64'd0);
        chk("sw_block_gnt", 64'(mgr_rsp.gnt), 64'd0);
        cyc(); rsp(0, 32'hF1A5_0001, 4'd1); #1;
        chk("sw_flash_rv",  64'({mgr_rsp.rvalid, mgr_rsp.r.rdata}), {31'd0, 1'b1, 32'hF1A5_0001});
        chk("sw_still_blk", 64'(mgr_rsp.gnt), 64'd0);
        cyc(); clr_rvalid(); #1;
        chk("sw_psram_req", 64'(req_vec()), 64'b000100);
        chk("sw_psram_gnt", 64'(mgr_rsp.gnt), 64'd1);
        cyc(); drv(1'b0, '0, 1'b0, 4'd0); sbr_rsp[2].gnt = 1'b0; rsp(4, 32'hDEAD, 4'd2); #1;
        chk("spur_rv",   64'(mgr_rsp.rvalid), 64'd0);
        cyc(); clr_rvalid(); rsp(2, 32'h2222_0000, 4'd2); #1;
        chk("spur_busy", 64'(busy), 64'd1);
        chk("sw_psram_rv", 64'({mgr_rsp.rvalid, mgr_rsp.r.rdata}), {31'd0, 1'b1, 32'h2222_0000});
        cyc(); clr_rvalid(); #1;
        chk("sw_idle", 64'(busy), 64'd0);

        // Reset mid-flight with cnt=2
        sbr_rsp[0].gnt = 1'b1;
        cyc(); drv(1'b1, 32'h0000_0200, 1'b0, 4'd3); #1;
        cyc(); drv(1'b1, 32'h0000_0204, 1'b0, 4'd4); #1;
        chk("mid_gnt2", 64'(mgr_rsp.gnt), 64'd1);
        cyc(); drv(1'b0, '0, 1'b0, 4'd0); sbr_rsp[0].gnt = 1'b0; rst = 1'b1; #1;
        chk("mid_busy_pre", 64'(busy), 64'd1);
        cyc(); rst = 1'b0; #1;
        chk("mid_busy",    64'(busy), 64'd0);
        chk("mid_mgr_rsp", 64'(mgr_rsp), 64'd0);
        chk("mid_req_vec", 64'(req_vec()), 64'd0);
        cyc(); rsp(0, 32'h1A7E_0000, 4'd3); #1;
        chk("late_rv",   64'(mgr_rsp.rvalid), 64'd0);
        cyc(); clr_rvalid(); #1;
        chk("late_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
